// File: rtl/itlb_refill_ctrl_pkg.sv
// itlb_refill_ctrl_pkg: shared widths, FSM state type and refill capture record for the ITLB refill path.
package itlb_refill_ctrl_pkg;
   localparam int VPN_W       = 27;
   localparam int PTE_W       = 64;
   localparam int ENTRY_N     = 32;
   localparam int TIMEOUT_CYC = 255;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, SEL, WRITE, DROP} refill_state_e;
   typedef struct packed {
      logic [VPN_W-1:0] vpn;
      logic [PTE_W-1:0] pte;
   } refill_req_t;
endpackage

// File: rtl/itlb_refill_ctrl_if.sv
// itlb_refill_ctrl_if: lookup, PTW, PLRU and TLB-write signals of the refill controller.
interface itlb_refill_ctrl_if;
   import itlb_refill_ctrl_pkg::*;
   logic               miss_vld_i;
   logic [VPN_W-1:0]   miss_vpn_i;
   logic               miss_rdy_o;
   logic               flush_i;
   logic               ptw_req_vld_o;
   logic               ptw_req_rdy_i;
   logic [VPN_W-1:0]   ptw_req_vpn_o;
   logic               ptw_rsp_vld_i;
   logic [PTE_W-1:0]   ptw_rsp_pte_i;
   logic               ptw_rsp_fault_i;
   logic               plru_init_en_o;
   logic               plru_refill_vld_o;
   logic [ENTRY_N-1:0] plru_onehot_i;
   logic               tlb_wr_en_o;
   logic [ENTRY_N-1:0] tlb_wr_onehot_o;
   logic [VPN_W-1:0]   tlb_wr_vpn_o;
   logic [PTE_W-1:0]   tlb_wr_pte_o;
   logic               done_vld_o;
   logic               done_fault_o;
   logic               busy_o;
   modport master (
      input  miss_vld_i, miss_vpn_i, flush_i, ptw_req_rdy_i, ptw_rsp_vld_i,
             ptw_rsp_pte_i, ptw_rsp_fault_i, plru_onehot_i,
      output miss_rdy_o, ptw_req_vld_o, ptw_req_vpn_o, plru_init_en_o, plru_refill_vld_o,
             tlb_wr_en_o, tlb_wr_onehot_o, tlb_wr_vpn_o, tlb_wr_pte_o,
             done_vld_o, done_fault_o, busy_o
   );
   modport slave (
      output miss_vld_i, miss_vpn_i, flush_i, ptw_req_rdy_i, ptw_rsp_vld_i,
             ptw_rsp_pte_i, ptw_rsp_fault_i, plru_onehot_i,
      input  miss_rdy_o, ptw_req_vld_o, ptw_req_vpn_o, plru_init_en_o, plru_refill_vld_o,
             tlb_wr_en_o, tlb_wr_onehot_o, tlb_wr_vpn_o, tlb_wr_pte_o,
             done_vld_o, done_fault_o, busy_o
   );
endinterface

// File: rtl/itlb_refill_ctrl.sv
// itlb_refill_ctrl: sequences one ITLB miss refill through PTW walk, PLRU victim select and TLB write.
// Define ITLB_REFILL_TIMEOUT_EN to add a WAIT-state watchdog that faults a stalled walk.
module itlb_refill_ctrl
   import itlb_refill_ctrl_pkg::*;
(
   input  logic               clk_i,
   input  logic               rstn_i,
   itlb_refill_ctrl_if.master bus
);
   refill_state_e r_state;
   refill_req_t   r_req;
   logic          r_kill;
   logic          r_done;
   logic          r_fault;
   logic          w_wr;
   logic          w_tmo;
`ifdef ITLB_REFILL_TIMEOUT_EN
   logic [7:0]    r_cnt;
   assign w_tmo = r_cnt == 8'(TIMEOUT_CYC);
   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) r_cnt <= '0;
      else         r_cnt <= r_state == WAIT ? r_cnt + 8'd1 : '0;
`else
   assign w_tmo = 1'b0;
`endif
   // A flush in the WRITE cycle must squash the write combinationally.
   assign w_wr                  = r_state == WRITE && !bus.flush_i;
   assign bus.miss_rdy_o        = r_state == IDLE;
   assign bus.busy_o            = r_state != IDLE;
   assign bus.ptw_req_vld_o     = r_state == REQ;
   assign bus.ptw_req_vpn_o     = r_req.vpn;
   assign bus.plru_init_en_o    = r_state == SEL;
   assign bus.plru_refill_vld_o = w_wr;
   assign bus.tlb_wr_en_o       = w_wr;
   assign bus.tlb_wr_onehot_o   = bus.plru_onehot_i;
   assign bus.tlb_wr_vpn_o      = r_req.vpn;
   assign bus.tlb_wr_pte_o      = r_req.pte;
   assign bus.done_vld_o        = r_done | w_wr;
   assign bus.done_fault_o      = r_fault;
   always_ff @(posedge clk_i or negedge rstn_i)
      if (!rstn_i) begin
         r_state <= IDLE;
         r_req   <= '0;
         r_kill  <= 1'b0;
         r_done  <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_fault <= 1'b0;
         case (r_state)
            IDLE:
               if (bus.miss_vld_i && !bus.flush_i) begin
                  r_req.vpn <= bus.miss_vpn_i;
                  r_kill    <= 1'b0;
                  r_state   <= REQ;
               end
            REQ:
               if (bus.ptw_req_rdy_i) r_state <= (r_kill || bus.flush_i) ? DROP : WAIT;
               else if (bus.flush_i)  r_kill  <= 1'b1;
            WAIT:
               // A response arriving with flush is already consumed, so go straight home.
               if (bus.ptw_rsp_vld_i) begin
                  r_state <= (bus.flush_i || bus.ptw_rsp_fault_i) ? IDLE : SEL;
                  r_done  <= !bus.flush_i && bus.ptw_rsp_fault_i;
                  r_fault <= !bus.flush_i && bus.ptw_rsp_fault_i;
                  if (!bus.flush_i && !bus.ptw_rsp_fault_i) r_req.pte <= bus.ptw_rsp_pte_i;
               end else if (bus.flush_i) r_state <= DROP;
               else if (w_tmo) begin
                  r_state <= DROP;
                  r_done  <= 1'b1;
                  r_fault <= 1'b1;
               end
            DROP:    if (bus.ptw_rsp_vld_i) r_state <= IDLE;
            SEL:     r_state <= bus.flush_i ? IDLE : WRITE;
            WRITE:   r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// tb_itlb_refill_ctrl: directed checks of the ITLB refill controller sequencing.
module tb_itlb_refill_ctrl;
   import itlb_refill_ctrl_pkg::*;
   logic clk_i = 1'b0;
   logic rstn_i = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   itlb_refill_ctrl_if bus();
   itlb_refill_ctrl dut (.clk_i(clk_i), .rstn_i(rstn_i), .bus(bus));
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic start_miss(input logic [VPN_W-1:0] vpn);
      bus.miss_vld_i = 1'b1;
      bus.miss_vpn_i = vpn;
      tick();
      bus.miss_vld_i = 1'b0;
   endtask

   initial begin
      bus.miss_vld_i      = 1'b0;
      bus.miss_vpn_i      = '0;
      bus.flush_i         = 1'b0;
      bus.ptw_req_rdy_i   = 1'b0;
      bus.ptw_rsp_vld_i   = 1'b0;
      bus.ptw_rsp_pte_i   = '0;
      bus.ptw_rsp_fault_i = 1'b0;
      bus.plru_onehot_i   = 32'h1 << 7;
      #12;
      chk("rst_miss_rdy", 64'(bus.miss_rdy_o), 64'd1);
      chk("rst_busy", 64'(bus.busy_o), 64'd0);
      chk("rst_req_vld", 64'(bus.ptw_req_vld_o), 64'd0);
      chk("rst_done", 64'(bus.done_vld_o), 64'd0);
      chk("rst_wr_en", 64'(bus.tlb_wr_en_o), 64'd0);
      chk("rst_vpn", 64'(bus.ptw_req_vpn_o), 64'd0);
      rstn_i = 1'b1;
      tick();
      // 1: good refill
      bus.ptw_req_rdy_i = 1'b1;
      start_miss(27'h12345);
      chk("t1_req_vld", 64'(bus.ptw_req_vld_o), 64'd1);
      chk("t1_req_vpn", 64'(bus.ptw_req_vpn_o), 64'h12345);
      chk("t1_miss_rdy_busy", 64'(bus.miss_rdy_o), 64'd0);
      tick();
      chk("t1_req_drop", 64'(bus.ptw_req_vld_o), 64'd0);
      tick();
      tick();
      tick();
      chk("t1_no_done_wait", 64'(bus.done_vld_o), 64'd0);
      bus.ptw_rsp_vld_i = 1'b1;
      bus.ptw_rsp_pte_i = 64'hABCD;
      tick();
      bus.ptw_rsp_vld_i = 1'b0;
      chk("t1_init_en", 64'(bus.plru_init_en_o), 64'd1);
      chk("t1_wr_early", 64'(bus.tlb_wr_en_o), 64'd0);
      tick();
      chk("t1_init_once", 64'(bus.plru_init_en_o), 64'd0);
      chk("t1_wr_en", 64'(bus.tlb_wr_en_o), 64'd1);
      chk("t1_refill", 64'(bus.plru_refill_vld_o), 64'd1);
      chk("t1_onehot", 64'(bus.tlb_wr_onehot_o), 64'h80);
      chk("t1_wr_vpn", 64'(bus.tlb_wr_vpn_o), 64'h12345);
      chk("t1_wr_pte", bus.tlb_wr_pte_o, 64'hABCD);
      chk("t1_done", 64'(bus.done_vld_o), 64'd1);
      chk("t1_fault", 64'(bus.done_fault_o), 64'd0);
      tick();
      chk("t1_wr_pulse", 64'(bus.tlb_wr_en_o), 64'd0);
      chk("t1_done_pulse", 64'(bus.done_vld_o), 64'd0);
      chk("t1_idle", 64'(bus.miss_rdy_o), 64'd1);
      // 2: PTW backpressure holds the request
      bus.ptw_req_rdy_i = 1'b0;
      start_miss(27'h5A5A5);
      for (int i = 0; i < 5; i++) begin
         chk("t2_req_hold", 64'(bus.ptw_req_vld_o), 64'd1);
         chk("t2_vpn_hold", 64'(bus.ptw_req_vpn_o), 64'h5A5A5);
         tick();
      end
      bus.ptw_req_rdy_i = 1'b1;
      tick();
      chk("t2_accepted", 64'(bus.ptw_req_vld_o), 64'd0);
      chk("t2_busy", 64'(bus.busy_o), 64'd1);
      // 3: walk fault
      bus.ptw_rsp_vld_i   = 1'b1;
      bus.ptw_rsp_fault_i = 1'b1;
      #1;
      chk("t3_done_not_yet", 64'(bus.done_vld_o), 64'd0);
      tick();
      bus.ptw_rsp_vld_i   = 1'b0;
      bus.ptw_rsp_fault_i = 1'b0;
      chk("t3_done", 64'(bus.done_vld_o), 64'd1);
      chk("t3_fault", 64'(bus.done_fault_o), 64'd1);
      chk("t3_wr_en", 64'(bus.tlb_wr_en_o), 64'd0);
      chk("t3_init", 64'(bus.plru_init_en_o), 64'd0);
      chk("t3_refill", 64'(bus.plru_refill_vld_o), 64'd0);
      chk("t3_idle", 64'(bus.miss_rdy_o), 64'd1);
      tick();
      chk("t3_done_pulse", 64'(bus.done_vld_o), 64'd0);
      // 4: flush in WAIT, late response absorbed
      start_miss(27'h11111);
      tick();
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         chk("t4_drop_busy", 64'(bus.busy_o), 64'd1);
         chk("t4_no_done", 64'(bus.done_vld_o), 64'd0);
         tick();
      end
      bus.ptw_rsp_vld_i = 1'b1;
      bus.ptw_rsp_pte_i = 64'h5555;
      tick();
      bus.ptw_rsp_vld_i = 1'b0;
      chk("t4_idle", 64'(bus.miss_rdy_o), 64'd1);
      chk("t4_no_done_end", 64'(bus.done_vld_o), 64'd0);
      chk("t4_no_init", 64'(bus.plru_init_en_o), 64'd0);
      chk("t4_no_wr", 64'(bus.tlb_wr_en_o), 64'd0);
      // 5: flush in WRITE squashes the write
      start_miss(27'h22222);
      tick();
      bus.ptw_rsp_vld_i = 1'b1;
      bus.ptw_rsp_pte_i = 64'h1234;
      tick();
      bus.ptw_rsp_vld_i = 1'b0;
      tick();
      bus.flush_i = 1'b1;
      #1;
      chk("t5_wr_en", 64'(bus.tlb_wr_en_o), 64'd0);
      chk("t5_refill", 64'(bus.plru_refill_vld_o), 64'd0);
      chk("t5_done", 64'(bus.done_vld_o), 64'd0);
      tick();
      bus.flush_i = 1'b0;
      chk("t5_idle", 64'(bus.miss_rdy_o), 64'd1);
      start_miss(27'h33333);
      chk("t5_next_req", 64'(bus.ptw_req_vld_o), 64'd1);
      chk("t5_next_vpn", 64'(bus.ptw_req_vpn_o), 64'h33333);
      tick();
      bus.ptw_rsp_vld_i = 1'b1;
      bus.ptw_rsp_pte_i = 64'h77;
      tick();
      bus.ptw_rsp_vld_i = 1'b0;
      tick();
      chk("t5_next_wr", 64'(bus.tlb_wr_en_o), 64'd1);
      chk("t5_next_pte", bus.tlb_wr_pte_o, 64'h77);
      chk("t5_next_wvpn", 64'(bus.tlb_wr_vpn_o), 64'h33333);
      tick();
      // flush with a miss in IDLE blocks capture; response in IDLE ignored
      bus.miss_vld_i = 1'b1;
      bus.miss_vpn_i = 27'h44444;
      bus.flush_i    = 1'b1;
      tick();
      bus.miss_vld_i = 1'b0;
      bus.flush_i    = 1'b0;
      chk("flush_idle_busy", 64'(bus.busy_o), 64'd0);
      chk("flush_idle_vpn", 64'(bus.ptw_req_vpn_o), 64'h33333);
      bus.ptw_rsp_vld_i = 1'b1;
      tick();
      bus.ptw_rsp_vld_i = 1'b0;
      chk("rsp_idle_ignored", 64'(bus.busy_o), 64'd0);
      // async reset mid-refill
      start_miss(27'h66666);
      tick();
      #2;
      rstn_i = 1'b0;
      #1;
      chk("arst_busy", 64'(bus.busy_o), 64'd0);
      chk("arst_vpn", 64'(bus.ptw_req_vpn_o), 64'd0);
      rstn_i = 1'b1;
      bus.ptw_rsp_vld_i = 1'b1;
      tick();
      bus.ptw_rsp_vld_i = 1'b0;
      chk("arst_rsp_ignored", 64'(bus.busy_o), 64'd0);
      chk("arst_no_init", 64'(bus.plru_init_en_o), 64'd0);
`ifdef ITLB_REFILL_TIMEOUT_EN
      // 6: watchdog fires on a silent walk
      begin
         int cyc = 0;
         start_miss(27'h0ABCD);
         tick();
         while (!bus.done_vld_o && cyc < 400) begin
            tick();
            cyc++;
         end
         chk("t6_done_seen", 64'(bus.done_vld_o), 64'd1);
         chk("t6_fault", 64'(bus.done_fault_o), 64'd1);
         chk("t6_wr_en", 64'(bus.tlb_wr_en_o), 64'd0);
         chk("t6_drop_busy", 64'(bus.busy_o), 64'd1);
         tick();
         bus.ptw_rsp_vld_i = 1'b1;
         tick();
         bus.ptw_rsp_vld_i = 1'b0;
         chk("t6_idle", 64'(bus.busy_o), 64'd0);
         chk("t6_no_done", 64'(bus.done_vld_o), 64'd0);
      end
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
